// File: rtl/adder_pkg.sv
// Shared operation encoding and signed-limit helpers for pipelined_adder.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int MAX_WIDTH = 64;

  function automatic logic [MAX_WIDTH-1:0] signed_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] signed_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational N-bit ripple slice with carry-in and carry-out.
module add_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// Carry-chain pipelined add/subtract with a global valid/ready stall.
// Define PIPELINED_ADDER_SAT_EN to add the sat port (signed saturation).
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SW = WIDTH / STAGES;
  localparam logic [MAX_WIDTH-1:0] SMAX_L = signed_max(WIDTH);
  localparam logic [MAX_WIDTH-1:0] SMIN_L = signed_min(WIDTH);
  localparam logic [WIDTH-1:0] SMAX = SMAX_L[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMIN = SMIN_L[WIDTH-1:0];

  logic             en;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             sat_in;

  assign in_ready = !out_valid || out_ready;
  assign en       = in_ready;
  assign is_sub   = (op_e'(op) == OP_SUB);
  assign b_eff    = is_sub ? ~b : b;
  assign cin_eff  = is_sub ? 1'b1 : cin;

`ifdef PIPELINED_ADDER_SAT_EN
  assign sat_in = sat;
`else
  assign sat_in = 1'b0;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [SW-1:0] sa, sb, ss;
    logic          ci, co, vin, sat_k;

    if (k == 0) begin : g_src0
      assign sa    = a[SW-1:0];
      assign sb    = b_eff[SW-1:0];
      assign ci    = cin_eff;
      assign vin   = in_valid;
      assign sat_k = sat_in;
    end else begin : g_srcn
      assign sa    = g_stg[k-1].g_mid.a_up[SW-1:0];
      assign sb    = g_stg[k-1].g_mid.b_up[SW-1:0];
      assign ci    = g_stg[k-1].g_mid.c_q;
      assign vin   = g_stg[k-1].g_mid.v_q;
      assign sat_k = g_stg[k-1].g_mid.sat_q;
    end

    add_slice #(.N(SW)) u_slice (
      .a    (sa),
      .b    (sb),
      .cin  (ci),
      .sum  (ss),
      .cout (co)
    );

    if (k < STAGES - 1) begin : g_mid
      // Upper operand slices ride along until their stage; lower sums accumulate.
      localparam int UW = WIDTH - (k + 1) * SW;
      logic                  v_q, c_q, sat_q;
      logic [(k+1)*SW-1:0]   sum_q, sum_nx;
      logic [UW-1:0]         a_up, b_up, a_nx, b_nx;

      if (k == 0) begin : g_first
        assign a_nx   = a[WIDTH-1:SW];
        assign b_nx   = b_eff[WIDTH-1:SW];
        assign sum_nx = ss;
      end else begin : g_next
        assign a_nx   = g_stg[k-1].g_mid.a_up[UW+SW-1:SW];
        assign b_nx   = g_stg[k-1].g_mid.b_up[UW+SW-1:SW];
        assign sum_nx = {ss, g_stg[k-1].g_mid.sum_q};
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q   <= 1'b0;
          c_q   <= 1'b0;
          sat_q <= 1'b0;
          sum_q <= '0;
          a_up  <= '0;
          b_up  <= '0;
        end else if (en) begin
          v_q   <= vin;
          c_q   <= co;
          sat_q <= sat_k;
          sum_q <= sum_nx;
          a_up  <= a_nx;
          b_up  <= b_nx;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] full, res_nx;
      logic             ovf_nx;

      if (k == 0) begin : g_single
        assign full = ss;
      end else begin : g_join
        assign full = {ss, g_stg[k-1].g_mid.sum_q};
      end

      assign ovf_nx = (sa[SW-1] == sb[SW-1]) && (ss[SW-1] != sa[SW-1]);
      assign res_nx = (sat_k && ovf_nx) ? (sa[SW-1] ? SMIN : SMAX) : full;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          result    <= '0;
          carry_out <= 1'b0;
          overflow  <= 1'b0;
        end else if (en) begin
          out_valid <= vin;
          result    <= res_nx;
          carry_out <= co;
          overflow  <= ovf_nx;
        end
      end
    end
  end

endmodule
